// File: rtl/ultrasonic_pkg.sv
// Shared state encoding and default timing for the round-robin
// HC-SR04 ranging scheduler (defaults are cycles at 50 MHz).
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF,
        NEXT
    } state_t;

    localparam int MAX_SENSORS = 8;
    localparam int IDX_W       = $clog2(MAX_SENSORS);

    localparam int DEF_N_SENSORS        = 2;
    localparam int DEF_CM_W             = 16;
    localparam int DEF_TRIG_CYCLES      = 500;
    localparam int DEF_CYCLES_PER_CM    = 2900;
    localparam int DEF_SLOT_CYCLES      = 5000000;
    localparam int DEF_ECHO_WAIT_CYCLES = 1500000;
    localparam int DEF_MAX_CM           = 400;

endpackage

// File: rtl/ultrasonic_scheduler_echo_sync_edge.sv
// One echo pin: two-flop synchronizer followed by a registered
// rise/fall detector; edges appear three cycles after the pin moves.
module echo_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Time-shares one trigger/echo timing engine across N sensors in
// fixed-length slots and latches a distance register per sensor.
module ultrasonic_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int N_SENSORS        = DEF_N_SENSORS,
    parameter int TRIG_CYCLES      = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM    = DEF_CYCLES_PER_CM,
    parameter int SLOT_CYCLES      = DEF_SLOT_CYCLES,
    parameter int ECHO_WAIT_CYCLES = DEF_ECHO_WAIT_CYCLES,
    parameter int MAX_CM           = DEF_MAX_CM,
    parameter int CM_W             = DEF_CM_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_SENSORS-1:0]      echo,
    output logic [N_SENSORS-1:0]      trigger,
    output logic [N_SENSORS*CM_W-1:0] dist_cm,
    output logic                      valid,
    output logic [IDX_W-1:0]          sensor_id,
    output logic                      timeout,
    output logic                      busy
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);
    localparam int WAIT_W = $clog2(ECHO_WAIT_CYCLES + 1);
    localparam int SUB_W  = $clog2(CYCLES_PER_CM + 1);

    localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [CM_W-1:0]   CM_MAX    = CM_W'(MAX_CM);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SENSORS - 1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nx;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [SUB_W-1:0]     sub;
    logic [SUB_W-1:0]     sub_n;
    logic [CM_W-1:0]      cm;
    logic [CM_W-1:0]      cm_n;
    logic [N_SENSORS-1:0] rise_vec;
    logic [N_SENSORS-1:0] fall_vec;
    logic [N_SENSORS-1:0] sel;
    logic [N_SENSORS-1:0] sel_nx;
    logic                 cur_rise;
    logic                 cur_fall;
    logic                 wr;
    logic                 wr_to;
    logic [CM_W-1:0]      wr_cm;

    function automatic logic [N_SENSORS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_SENSORS-1:0] v;
        v = '0;
        for (int k = 0; k < N_SENSORS; k++) begin
            v[k] = (i == IDX_W'(k));
        end
        return v;
    endfunction

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_sync
        echo_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (echo[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i])
        );
    end

    assign idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign sel      = onehot(idx);
    assign sel_nx   = onehot(idx_nx);
    assign cur_rise = |(rise_vec & sel);
    assign cur_fall = |(fall_vec & sel);
    assign busy     = (state != IDLE);

    // A fall that coincides with reaching MAX_CM is reported as a real echo.
    always_comb begin
        sub_n = sub + 1'b1;
        cm_n  = cm;
        if (sub == SUB_LAST) begin
            sub_n = '0;
            cm_n  = cm + 1'b1;
        end
        wr    = 1'b0;
        wr_to = 1'b0;
        wr_cm = cm_n;
        unique case (state)
            WAIT_RISE: begin
                if (!cur_rise && wait_cnt == WAIT_LAST) begin
                    wr    = 1'b1;
                    wr_to = 1'b1;
                    wr_cm = CM_MAX;
                end
            end
            MEASURE: begin
                if (cur_fall) begin
                    wr = 1'b1;
                end else if (cm_n == CM_MAX) begin
                    wr    = 1'b1;
                    wr_to = 1'b1;
                    wr_cm = CM_MAX;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            slot_cnt  <= '0;
            wait_cnt  <= '0;
            sub       <= '0;
            cm        <= '0;
            trigger   <= '0;
            dist_cm   <= '0;
            valid     <= 1'b0;
            sensor_id <= '0;
            timeout   <= 1'b0;
        end else begin
            valid    <= 1'b0;
            slot_cnt <= slot_cnt + 1'b1;
            if (wr) begin
                valid     <= 1'b1;
                timeout   <= wr_to;
                sensor_id <= idx;
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (sel[i]) dist_cm[i*CM_W +: CM_W] <= wr_cm;
                end
            end
            unique case (state)
                IDLE: begin
                    slot_cnt <= '0;
                    if (enable) begin
                        state   <= TRIG;
                        trigger <= sel;
                    end
                end
                TRIG: begin
                    if (slot_cnt == TRIG_LAST) begin
                        trigger  <= '0;
                        wait_cnt <= '0;
                        state    <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (cur_rise) begin
                        sub   <= '0;
                        cm    <= '0;
                        state <= MEASURE;
                    end else if (wr) begin
                        state <= HOLDOFF;
                    end
                end
                MEASURE: begin
                    sub <= sub_n;
                    cm  <= cm_n;
                    if (wr) state <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (slot_cnt >= SLOT_LAST) state <= NEXT;
                end
                NEXT: begin
                    idx      <= idx_nx;
                    slot_cnt <= '0;
                    if (enable) begin
                        state   <= TRIG;
                        trigger <= sel_nx;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing:
// slot 200, trigger 5, 4 cycles/cm, echo wait 50, max 20 cm.
module tb_ultrasonic_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  echo;
    logic [1:0]  trigger;
    logic [31:0] dist_cm;
    logic        valid;
    logic [2:0]  sensor_id;
    logic        timeout;
    logic        busy;

    int cyc     = 0;
    int nvalid  = 0;
    int n_checks = 0;
    int n_errors = 0;

    ultrasonic_scheduler #(
        .N_SENSORS        (2),
        .TRIG_CYCLES      (5),
        .CYCLES_PER_CM    (4),
        .SLOT_CYCLES      (200),
        .ECHO_WAIT_CYCLES (50),
        .MAX_CM           (20),
        .CM_W             (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .echo      (echo),
        .trigger   (trigger),
        .dist_cm   (dist_cm),
        .valid     (valid),
        .sensor_id (sensor_id),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) nvalid <= nvalid + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_trig(input int i, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (trigger[i]) begin
                t = cyc;
                break;
            end
        end
        check("trig_seen", int'(t >= 0), 1);
    endtask

    task automatic wait_valid(output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (valid) begin
                t = cyc;
                break;
            end
        end
        check("valid_seen", int'(t >= 0), 1);
    endtask

    int t0, t1, t2, t3, t4, t5, t6, th, tv, f, r, n, v0, nv, x;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        echo   = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_trigger", int'(trigger), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dist", int'(dist_cm), 0);
        check("rst_id", int'(sensor_id), 0);
        check("rst_timeout", int'(timeout), 0);

        // slot A, sensor 0: 40-cycle echo -> 10 cm
        reset  = 1'b0;
        enable = 1'b1;
        wait_trig(0, t0);
        n = 0;
        while (trigger[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("a_trig_width", n, 5);
        repeat (10) @(negedge clk);
        echo[0] = 1'b1;
        repeat (40) @(negedge clk);
        echo[0] = 1'b0;
        f = cyc;
        wait_valid(tv);
        check("a_latency", tv - (f + 1), 3);
        check("a_id", int'(sensor_id), 0);
        check("a_dist0", int'(dist_cm[15:0]), 10);
        check("a_timeout", int'(timeout), 0);
        @(negedge clk);
        check("a_valid_pulse", int'(valid), 0);

        // slot B, sensor 1: 13-cycle echo -> 3 cm
        wait_trig(1, t1);
        check("b_slot_period", t1 - t0, 201);
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        repeat (13) @(negedge clk);
        echo[1] = 1'b0;
        wait_valid(tv);
        check("b_id", int'(sensor_id), 1);
        check("b_dist1", int'(dist_cm[31:16]), 3);
        check("b_timeout", int'(timeout), 0);
        check("b_dist0_kept", int'(dist_cm[15:0]), 10);

        // slot C, sensor 0: no echo, echo[1] toggling must be ignored
        wait_trig(0, t2);
        check("c_slot_period", t2 - t1, 201);
        v0 = nvalid;
        repeat (8) @(negedge clk);
        echo[1] = 1'b1;
        repeat (10) @(negedge clk);
        echo[1] = 1'b0;
        repeat (4) @(negedge clk);
        echo[1] = 1'b1;
        repeat (4) @(negedge clk);
        echo[1] = 1'b0;
        wait_valid(tv);
        check("c_latency", tv - t2, 55);
        check("c_timeout", int'(timeout), 1);
        check("c_id", int'(sensor_id), 0);
        check("c_dist0", int'(dist_cm[15:0]), 20);
        check("c_dist1_kept", int'(dist_cm[31:16]), 3);

        // slot D, sensor 1: 80-cycle echo, fall ties with saturation
        wait_trig(1, t3);
        check("d_slot_period", t3 - t2, 201);
        check("c_one_valid", nvalid - v0, 1);
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        repeat (80) @(negedge clk);
        echo[1] = 1'b0;
        wait_valid(tv);
        check("d_id", int'(sensor_id), 1);
        check("d_dist1", int'(dist_cm[31:16]), 20);
        check("d_timeout", int'(timeout), 0);

        // slot E, sensor 0: overlong echo saturates at 80th measure cycle
        wait_trig(0, t4);
        check("e_slot_period", t4 - t3, 201);
        repeat (5) @(negedge clk);
        echo[0] = 1'b1;
        r = cyc;
        wait_valid(tv);
        check("e_latency", tv - r, 84);
        check("e_timeout", int'(timeout), 1);
        check("e_dist0", int'(dist_cm[15:0]), 20);

        // slot F, sensor 1: 13-cycle echo again; echo[0] falls unobserved
        wait_trig(1, t5);
        echo[0] = 1'b0;
        check("f_slot_period", t5 - t4, 201);
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        repeat (13) @(negedge clk);
        echo[1] = 1'b0;
        wait_valid(tv);
        check("f_dist1", int'(dist_cm[31:16]), 3);
        check("f_timeout", int'(timeout), 0);
        repeat (5) @(negedge clk);
        echo[0] = 1'b1;

        // slot G, sensor 0: stale echo times out; enable dropped mid-slot
        wait_trig(0, t6);
        enable = 1'b0;
        wait_valid(tv);
        check("g_latency", tv - t6, 55);
        check("g_timeout", int'(timeout), 1);
        check("g_id", int'(sensor_id), 0);
        echo[0] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("g_idle_at", cyc - t6, 201);
        check("g_idle_trigger", int'(trigger), 0);
        nv = nvalid;
        repeat (20) @(negedge clk);
        check("g_idle_busy", int'(busy), 0);
        check("g_idle_no_valid", nvalid - nv, 0);

        // re-enable resumes with sensor 1
        x = cyc;
        enable = 1'b1;
        th = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (trigger != 2'b00) begin
                th = cyc;
                break;
            end
        end
        check("h_resume_delay", th - x, 1);
        check("h_resume_trigger", int'(trigger), 2);

        // reset during measure aborts without a result
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("h_busy_measure", int'(busy), 1);
        nv = nvalid;
        reset = 1'b1;
        @(negedge clk);
        check("h_rst_trigger", int'(trigger), 0);
        check("h_rst_valid", int'(valid), 0);
        check("h_rst_dist", int'(dist_cm), 0);
        check("h_rst_id", int'(sensor_id), 0);
        check("h_rst_timeout", int'(timeout), 0);
        check("h_rst_busy", int'(busy), 0);
        echo[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("h_rst_no_valid", nvalid - nv, 0);
        reset = 1'b0;
        wait_trig(0, t0);
        check("h_restart_trigger", int'(trigger), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
